// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee machine: ingredient codes, the
// dispense duration table and the dispense timer state encoding.
package coffee_pkg;

  // Width of the tick prescaler; covers TICK_DIV up to 2^26-1.
  localparam int PRESC_W = 26;

  typedef enum logic [2:0] {
    ING_WATER     = 3'd0,
    ING_COFFEE    = 3'd1,
    ING_MILK      = 3'd2,
    ING_CHOCOLATE = 3'd3,
    ING_SUGAR     = 3'd4,
    ING_CREAM     = 3'd5,
    ING_HEAT      = 3'd6,
    ING_NONE      = 3'd7
  } ing_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  // Dispense duration in timer ticks for each ingredient code.
  function automatic logic [7:0] dispense_ticks(input logic [2:0] code);
    logic [7:0] ticks;
    case (ing_e'(code))
      ING_WATER:     ticks = 8'd8;
      ING_COFFEE:    ticks = 8'd6;
      ING_MILK:      ticks = 8'd5;
      ING_CHOCOLATE: ticks = 8'd4;
      ING_SUGAR:     ticks = 8'd2;
      ING_CREAM:     ticks = 8'd3;
      ING_HEAT:      ticks = 8'd10;
      default:       ticks = 8'd0;
    endcase
    return ticks;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled clk cycles and flags every TICK_DIV-th one.
// tick is asserted combinationally during the cycle whose rising edge
// completes the period; clear has priority and restarts the period.
module tick_gen
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] count_q;
  logic [PRESC_W-1:0] count_d;

  assign tick = enable && (count_q == TERM);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == TERM) ? '0 : count_q + PRESC_W'(1);
    end
  end

  // Prescaler register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/dispense_timer.sv
// Dispense timer: times one ingredient at a time for the recipe FSM,
// counting whole ticks down from the table duration and pulsing
// t_expired for one cycle at the end. All outputs are registered.
module dispense_timer
  import coffee_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [2:0] ing_type,
  input  logic       pause,
  output logic       t_expired,
  output logic       busy,
  output logic [7:0] remaining,
  output logic [2:0] cur_ing
);

  timer_state_e state_q, state_d;
  logic [7:0]   remaining_q, remaining_d;
  logic [2:0]   cur_ing_q, cur_ing_d;
  logic         busy_q, busy_d;
  logic         t_expired_q, t_expired_d;

  logic [7:0]   start_ticks;
  logic         tick;
  logic         tick_en;
  logic         tick_clr;

  assign start_ticks = dispense_ticks(ing_type);

  // The prescaler only runs in RUN with pause low; a start (re)aligns it.
  assign tick_en  = (state_q == ST_RUN) && !pause;
  assign tick_clr = start_timer || (state_q != ST_RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (tick_en),
    .clear  (tick_clr),
    .tick   (tick)
  );

  // Next-state and registered-output logic; start overrides every state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cur_ing_d   = cur_ing_q;
    busy_d      = busy_q;
    t_expired_d = 1'b0;

    if (start_timer) begin
      cur_ing_d   = ing_type;
      remaining_d = start_ticks;
      if (start_ticks == 8'd0) begin
        state_d     = ST_DONE;
        busy_d      = 1'b0;
        t_expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_RUN: begin
          if (tick && (remaining_q != 8'd0)) begin
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_d     = ST_DONE;
              busy_d      = 1'b0;
              t_expired_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          remaining_d = 8'd0;
        end
        default: begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          remaining_d = 8'd0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      cur_ing_q   <= 3'd0;
      busy_q      <= 1'b0;
      t_expired_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cur_ing_q   <= cur_ing_d;
      busy_q      <= busy_d;
      t_expired_q <= t_expired_d;
    end
  end

  assign t_expired = t_expired_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign cur_ing   = cur_ing_q;

endmodule

// File: tb/tb_dispense_timer.sv
// Bench for dispense_timer with TICK_DIV=4: directed scenarios followed
// by random start/pause/reset traffic, checked against an arithmetic
// model of the countdown and a queue of expected expiry pulses.
module tb_dispense_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [2:0] ing_type = 3'd0;
  logic       pause = 1'b0;
  logic       t_expired;
  logic       busy;
  logic [7:0] remaining;
  logic [2:0] cur_ing;

  dispense_timer #(
    .TICK_DIV (TD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_timer (start_timer),
    .ing_type    (ing_type),
    .pause       (pause),
    .t_expired   (t_expired),
    .busy        (busy),
    .remaining   (remaining),
    .cur_ing     (cur_ing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: duration in ticks per ingredient code.
  int dur_tbl[8] = '{8, 6, 5, 4, 2, 3, 10, 0};

  typedef struct {
    int         cyc;
    logic [2:0] ing;
  } exp_t;

  exp_t exp_q[$];

  // Model state: a countdown is described by its duration and the number
  // of unpaused edges elapsed since it was started.
  int         edge_cnt = 0;
  bit         m_run = 1'b0;
  int         m_d = 0;
  int         m_active = 0;
  logic [2:0] m_ing = 3'd0;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_run    = 1'b0;
        m_d      = 0;
        m_active = 0;
        m_ing    = 3'd0;
        exp_q.delete();
      end else if (clk) begin
        edge_cnt++;
        if (start_timer) begin
          m_ing    = ing_type;
          m_d      = dur_tbl[ing_type];
          m_active = 0;
          m_run    = (m_d != 0);
          if (m_d == 0) exp_q.push_back('{cyc: edge_cnt, ing: ing_type});
        end else if (m_run && !pause) begin
          m_active++;
          if (m_active == m_d * TD) begin
            m_run = 1'b0;
            exp_q.push_back('{cyc: edge_cnt, ing: m_ing});
          end
        end
      end
    end
  end

  // Monitor: compare visible outputs against the model mid-cycle and
  // consume one expected pulse whenever one falls due.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int  exp_rem;
        bit  exp_now;
        exp_rem = m_run ? (m_d - m_active / TD) : 0;
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
        check("busy", busy, m_run);
        check("remaining", remaining, exp_rem);
        check("cur_ing", cur_ing, m_ing);
        check("t_expired", t_expired, exp_now);
        if (exp_now) begin
          check("cur_ing at expiry", cur_ing, exp_q[0].ing);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic s, input logic [2:0] i, input logic p);
    start_timer = s;
    ing_type    = i;
    pause       = p;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with a wandering ing_type that must be ignored.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " t_expired"}, t_expired, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " remaining"}, remaining, 0);
    check({tag, " cur_ing"}, cur_ing, 0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Milk: five ticks of four cycles.
    step(1'b1, 3'd2, 1'b0);
    idle(25);

    // No-dispense code: immediate pulse, never busy.
    step(1'b1, 3'd7, 1'b0);
    idle(3);

    // Sugar with a three-cycle pause mid-run.
    step(1'b1, 3'd4, 1'b0);
    idle(3);
    for (int k = 0; k < 3; k++) step(1'b0, 3'($urandom_range(0, 7)), 1'b1);
    idle(12);

    // Coffee aborted by a chocolate restart.
    step(1'b1, 3'd1, 1'b0);
    idle(9);
    step(1'b1, 3'd3, 1'b0);
    idle(20);

    // Heat aborted by reset: outputs clear before any clock edge.
    step(1'b1, 3'd6, 1'b0);
    idle(6);
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(50);

    // Back-to-back: start issued during the DONE cycle, twice.
    step(1'b1, 3'd4, 1'b0);
    idle(8);
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd5, 1'b0);
    idle(16);

    // Start together with pause: loads, then holds.
    step(1'b1, 3'd5, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 3'd0, 1'b1);
    idle(16);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        step(($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0));
      end
    end

    // Let the last countdown finish, then every expected pulse must be seen.
    idle(50);
    check("pending expiry pulses", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
